tour_cmd_sequencer: RTL and testbench
=====================================

# tour_cmd_sequencer

Sequencer that replays a solved knight's tour as robot motion commands. It reads the 24 one-hot moves stored by the tour-logic solver through a synchronous read port and splits each knight move into two commands: a vertical leg, then a horizontal leg with fanfare. It issues them one at a time to the command-processor mux over a ready/clear handshake and waits for move completion (`send_resp`) before advancing.

## Interface
- `NUM_MOVES`, default 24: number of moves replayed per tour (25-square board).
- `MV_AW`, default 5: move-memory address width; must satisfy 2^MV_AW >= NUM_MOVES.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse: tour solved, begin replay.
- `mv_addr`  out  MV_AW  move-memory read address (registered).
- `mv_data`  in  8  one-hot move. Valid the cycle after `mv_addr` is presented.
- `cmd`  out  16  command word `{opcode[3:0], heading[7:0], squares[3:0]}`.
- `cmd_rdy`  out  1  `cmd` is valid and pending.
- `clr_cmd_rdy`  in  1  consumer accepted `cmd`.
- `send_resp`  in  1  pulse: the issued move has completed.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last horizontal leg completes.
- `err`  out  1  one-cycle pulse when a fetched move is not one-hot.

## Operation
- Move encoding, as (dy, dx) for each set bit:
  - b0 = (+2, +1), b1 = (+2, −1), b2 = (+1, −2), b3 = (−1, −2)
  - b4 = (−2, −1), b5 = (−2, +1), b6 = (−1, +2), b7 = (+1, +2)
- Vertical leg: opcode 4'h4, no fanfare. Heading is 8'h00 (north) if dy > 0, else 8'h7F (south). squares = |dy|.
- Horizontal leg: opcode 4'h5, fanfare. Heading is 8'hBF (east) if dx > 0, else 8'h3F (west). squares = |dx|.
- States and transitions:
  - IDLE → FETCH on `start`; the move index is cleared to 0.
  - FETCH: drives `mv_addr` = index. → LOAD.
  - LOAD: captures `mv_data`. If one-hot, latch the vertical `cmd` and → VERT. If not one-hot, pulse `err` and → IDLE.
  - VERT: `cmd_rdy` = 1. On `clr_cmd_rdy` → WAIT_V.
  - WAIT_V: on `send_resp`, load the horizontal `cmd` and → HORZ.
  - HORZ: `cmd_rdy` = 1. On `clr_cmd_rdy` → WAIT_H.
  - WAIT_H: on `send_resp`:
    - if index == NUM_MOVES−1, pulse `done` and → IDLE;
    - otherwise index++ and → FETCH.
- Boundary rules:
  - `start` is ignored while `busy`.
  - `send_resp` is ignored outside WAIT_V and WAIT_H, including when it coincides with `clr_cmd_rdy` in VERT or HORZ.
  - `clr_cmd_rdy` is ignored while `cmd_rdy` = 0.
  - `mv_data` = 8'h00 or any multi-bit value → `err`.
  - The index never wraps; it is bounded by NUM_MOVES−1.
- Reset (applies equally mid-tour):
  - state = IDLE, index = 0, `mv_addr` = 0, `cmd` = 16'h0000.
  - `cmd_rdy`, `busy`, `done`, `err` = 0.
  - Any pending command is dropped.

## Timing
- `start` sampled at edge N:
  - FETCH at N+1;
  - `mv_data` captured at N+2;
  - `cmd_rdy` and `cmd` valid from N+3.
- `cmd_rdy` falls on the edge that samples `clr_cmd_rdy`. `cmd` holds its value until the next leg is loaded.
- From `send_resp` sampled in WAIT_V, the horizontal `cmd_rdy` is asserted the next cycle.
- From `send_resp` sampled in WAIT_H, the next vertical `cmd_rdy` follows 3 cycles later (FETCH, LOAD, VERT).
- `done` and `err` each last exactly one cycle, coincident with the return to IDLE; `busy` is 0 in that same cycle.
- All outputs are registered.

## Structure
- Package `tour_pkg` holds:
  - state enum `tcs_state_t`;
  - opcode constants `OP_MOVE` = 4'h4, `OP_MOVE_FF` = 4'h5;
  - heading constants `HDG_N`, `HDG_S`, `HDG_E`, `HDG_W`;
  - the move-offset table.
- Sub-module `knight_move_decode` (combinational) maps the one-hot move to `vert_cmd[15:0]`, `horz_cmd[15:0]` and `legal`. It is shared with the tour logic for consistency.
- The sequencer holds only the FSM, the index counter and the `cmd` register.

## Test plan
- Single legal move: NUM_MOVES = 1, mv[0] = 8'h01, `start`.
  - `cmd` = 16'h4002 at N+3; after clr + `send_resp`, `cmd` = 16'h5BF1.
  - After the second `send_resp`, `done` pulses.
- West/south legs:
  - mv = 8'h04 → 16'h4001 then 16'h53F2;
  - mv = 8'h10 → 16'h47F2 then 16'h53F1.
- Full tour, NUM_MOVES = 24, memory loaded with a legal tour:
  - exactly 48 `cmd_rdy` assertions;
  - `mv_addr` sweeps 0..23;
  - `done` is a single pulse after the 48th `send_resp`, then `busy` = 0.
- Illegal move: mv[3] = 8'h03.
  - `err` pulses at LOAD; no `cmd_rdy` for index 3; `done` is never asserted.
- Protocol abuse, each ignored with no state change:
  - `start` while busy;
  - `send_resp` in VERT, same cycle as `clr_cmd_rdy`;
  - `clr_cmd_rdy` in WAIT_V.
- Assert `rst` during WAIT_H of move 10:
  - next cycle all outputs hold reset values;
  - a new `start` replays from `mv_addr` = 0.

Source files
------------

// File: rtl/tour_pkg.sv
// -----------------------------------------------------------------------------
// tour_pkg
// Shared definitions for the knight's-tour command path:
//   - tcs_state_t   : sequencer FSM states
//   - OP_*          : command-processor opcodes (plain move / move with fanfare)
//   - HDG_*         : robot headings for the four compass directions
//   - move_ofs()    : one-hot move bit -> (dy, dx) offset table
//   - *_leg_cmd()   : build the 16-bit {opcode, heading, squares} command words
// -----------------------------------------------------------------------------
package tour_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_VERT   = 3'd3,
        S_WAIT_V = 3'd4,
        S_HORZ   = 3'd5,
        S_WAIT_H = 3'd6
    } tcs_state_t;

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_MOVE_FF = 4'h5;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    typedef struct packed {
        logic signed [2:0] dy;
        logic signed [2:0] dx;
    } move_ofs_t;

    // Knight move offsets, indexed by the set bit of the one-hot move.
    function automatic move_ofs_t move_ofs(input int unsigned b);
        move_ofs_t m;
        case (b)
            0:       m = '{dy:  3'sd2, dx:  3'sd1};
            1:       m = '{dy:  3'sd2, dx: -3'sd1};
            2:       m = '{dy:  3'sd1, dx: -3'sd2};
            3:       m = '{dy: -3'sd1, dx: -3'sd2};
            4:       m = '{dy: -3'sd2, dx: -3'sd1};
            5:       m = '{dy: -3'sd2, dx:  3'sd1};
            6:       m = '{dy: -3'sd1, dx:  3'sd2};
            7:       m = '{dy:  3'sd1, dx:  3'sd2};
            default: m = '{dy:  3'sd0, dx:  3'sd0};
        endcase
        return m;
    endfunction

    function automatic logic [3:0] abs_squares(input logic signed [2:0] d);
        logic [2:0] mag;
        mag = d[2] ? 3'(-d) : 3'(d);
        return {1'b0, mag};
    endfunction

    // Vertical leg: no fanfare, north for positive dy.
    function automatic logic [15:0] vert_leg_cmd(input move_ofs_t m);
        return {OP_MOVE, (m.dy > 3'sd0) ? HDG_N : HDG_S, abs_squares(m.dy)};
    endfunction

    // Horizontal leg: with fanfare, east for positive dx.
    function automatic logic [15:0] horz_leg_cmd(input move_ofs_t m);
        return {OP_MOVE_FF, (m.dx > 3'sd0) ? HDG_E : HDG_W, abs_squares(m.dx)};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// -----------------------------------------------------------------------------
// knight_move_decode
// Combinational decode of a one-hot knight move into the two robot commands.
// Ports:
//   mv       in  8   one-hot move
//   vert_cmd out 16  vertical-leg command word
//   horz_cmd out 16  horizontal-leg command word (with fanfare)
//   legal    out 1   mv has exactly one bit set
// Command words are only meaningful when legal is high.
// -----------------------------------------------------------------------------
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  mv,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        legal
);

    logic [15:0] w_vert_terms [8];
    logic [15:0] w_horz_terms [8];

    // Each bit contributes a constant command word; with a one-hot input the
    // OR of all terms is simply the word for the set bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            localparam move_ofs_t   OFS   = move_ofs(gi);
            localparam logic [15:0] V_CMD = vert_leg_cmd(OFS);
            localparam logic [15:0] H_CMD = horz_leg_cmd(OFS);
            assign w_vert_terms[gi] = mv[gi] ? V_CMD : 16'h0000;
            assign w_horz_terms[gi] = mv[gi] ? H_CMD : 16'h0000;
        end
    endgenerate

    always_comb begin
        vert_cmd = 16'h0000;
        horz_cmd = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            vert_cmd = vert_cmd | w_vert_terms[i];
            horz_cmd = horz_cmd | w_horz_terms[i];
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign legal = (mv != 8'h00) && ((mv & (mv - 8'd1)) == 8'h00);

endmodule

// File: rtl/tour_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tour_cmd_sequencer
// Replays a solved knight's tour as robot motion commands. Each one-hot move
// read from the move memory becomes a vertical leg then a horizontal leg, each
// handed to the command mux over a cmd_rdy / clr_cmd_rdy handshake, with
// send_resp marking completion of the issued leg.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start        in   pulse, begin replay (ignored while busy)
//   mv_addr      out  move-memory read address (registered)
//   mv_data      in   one-hot move, valid the cycle after mv_addr
//   cmd          out  {opcode, heading, squares}
//   cmd_rdy      out  cmd pending
//   clr_cmd_rdy  in   consumer accepted cmd
//   send_resp    in   issued leg completed
//   busy         out  not idle
//   done         out  pulse, tour finished
//   err          out  pulse, fetched move not one-hot
// -----------------------------------------------------------------------------
module tour_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int MV_AW     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [MV_AW-1:0] mv_addr,
    input  logic [7:0]       mv_data,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [MV_AW-1:0] LAST_IDX = MV_AW'(NUM_MOVES - 1);
    localparam logic [MV_AW-1:0] IDX_ONE  = MV_AW'(1);

    tcs_state_t       r_state, w_state_next;
    logic [MV_AW-1:0] r_idx, w_idx_next;
    logic [MV_AW-1:0] r_addr, w_addr_next;
    logic [7:0]       r_mv, w_mv_next;
    logic [15:0]      r_cmd, w_cmd_next;
    logic             r_cmd_rdy, r_busy, r_done, r_err;
    logic             w_done_next, w_err_next;

    logic [7:0]       w_dec_mv;
    logic [15:0]      w_vert_cmd, w_horz_cmd;
    logic             w_legal;

    // In LOAD the decoder sees the live memory data; afterwards it sees the
    // captured move so the horizontal leg can be built when WAIT_V completes.
    assign w_dec_mv = (r_state == S_LOAD) ? mv_data : r_mv;

    knight_move_decode u_decode (
        .mv       (w_dec_mv),
        .vert_cmd (w_vert_cmd),
        .horz_cmd (w_horz_cmd),
        .legal    (w_legal)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_addr_next  = r_addr;
        w_mv_next    = r_mv;
        w_cmd_next   = r_cmd;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_next   = '0;
                    w_addr_next  = '0;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // mv_addr was set on entry; the memory reads it this cycle.
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_mv_next = mv_data;
                if (w_legal) begin
                    w_cmd_next   = w_vert_cmd;
                    w_state_next = S_VERT;
                end else begin
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_VERT: begin
                if (clr_cmd_rdy) begin
                    w_state_next = S_WAIT_V;
                end
            end
            S_WAIT_V: begin
                if (send_resp) begin
                    w_cmd_next   = w_horz_cmd;
                    w_state_next = S_HORZ;
                end
            end
            S_HORZ: begin
                if (clr_cmd_rdy) begin
                    w_state_next = S_WAIT_H;
                end
            end
            S_WAIT_H: begin
                if (send_resp) begin
                    if (r_idx == LAST_IDX) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next   = r_idx + IDX_ONE;
                        w_addr_next  = r_idx + IDX_ONE;
                        w_state_next = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_addr    <= '0;
            r_mv      <= 8'h00;
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_addr    <= w_addr_next;
            r_mv      <= w_mv_next;
            r_cmd     <= w_cmd_next;
            // Flags follow the state being entered so they line up with it.
            r_cmd_rdy <= (w_state_next == S_VERT) || (w_state_next == S_HORZ);
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    assign mv_addr = r_addr;
    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
module tb_tour_cmd_sequencer;

    localparam int NUM_MOVES = 24;
    localparam int MV_AW     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [MV_AW-1:0] mv_addr;
    logic [7:0]       mv_data;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic             busy;
    logic             done;
    logic             err;

    logic [7:0]       mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Move memory with a registered read port.
    always @(posedge clk) mv_data <= mem[mv_addr];

    tour_cmd_sequencer #(
        .NUM_MOVES (NUM_MOVES),
        .MV_AW     (MV_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mv_addr     (mv_addr),
        .mv_data     (mv_data),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Event monitor: samples settled outputs just before each rising edge.
    int               rdy_rises  = 0;
    int               done_cnt   = 0;
    int               err_cnt    = 0;
    int               addr_steps = 0;
    int               addr_bad   = 0;
    logic             prev_rdy   = 1'b0;
    logic [MV_AW-1:0] prev_addr  = '0;

    always @(posedge clk) begin
        if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rdy_rises++;
        prev_rdy = cmd_rdy;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (mv_addr !== prev_addr) begin
            if (mv_addr != prev_addr + 5'd1 && mv_addr != 5'd0) addr_bad++;
            if (mv_addr != 5'd0) addr_steps++;
            prev_addr = mv_addr;
        end
    end

    typedef struct {
        logic [7:0]  mv;
        logic        legal;
        logic [15:0] v;
        logic [15:0] h;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, output int waited);
        waited = 0;
        while (cmd_rdy !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    // One leg: wait for cmd_rdy, check word and latency, accept, complete.
    task automatic leg(input string nm, input logic [15:0] exp_cmd, input int exp_wait);
        int w;
        wait_rdy(10, w);
        chk({nm, " cmd_rdy"}, 32'(cmd_rdy), 32'd1);
        chk({nm, " latency"}, w, exp_wait);
        chk({nm, " cmd"}, 32'(cmd), 32'(exp_cmd));
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk({nm, " cmd_rdy cleared"}, 32'(cmd_rdy), 32'd0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic run_move(input int i);
        leg($sformatf("m%0d vert", i), vecs[i % 8].v, 2);
        leg($sformatf("m%0d horz", i), vecs[i % 8].h, 0);
        $display("[TB] move %0d mv=0x%02h legs 0x%04h 0x%04h", i, mem[i], vecs[i % 8].v, vecs[i % 8].h);
    endtask

    task automatic load_tour();
        for (int i = 0; i < 32; i++) mem[i] = 8'h01 << (i % 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, e0, s0, b0;

        vecs[0]  = '{mv: 8'h01, legal: 1'b1, v: 16'h4002, h: 16'h5BF1};
        vecs[1]  = '{mv: 8'h02, legal: 1'b1, v: 16'h4002, h: 16'h53F1};
        vecs[2]  = '{mv: 8'h04, legal: 1'b1, v: 16'h4001, h: 16'h53F2};
        vecs[3]  = '{mv: 8'h08, legal: 1'b1, v: 16'h47F1, h: 16'h53F2};
        vecs[4]  = '{mv: 8'h10, legal: 1'b1, v: 16'h47F2, h: 16'h53F1};
        vecs[5]  = '{mv: 8'h20, legal: 1'b1, v: 16'h47F2, h: 16'h5BF1};
        vecs[6]  = '{mv: 8'h40, legal: 1'b1, v: 16'h47F1, h: 16'h5BF2};
        vecs[7]  = '{mv: 8'h80, legal: 1'b1, v: 16'h4001, h: 16'h5BF2};
        vecs[8]  = '{mv: 8'h00, legal: 1'b0, v: 16'h0000, h: 16'h0000};
        vecs[9]  = '{mv: 8'h03, legal: 1'b0, v: 16'h0000, h: 16'h0000};
        vecs[10] = '{mv: 8'hFF, legal: 1'b0, v: 16'h0000, h: 16'h0000};

        load_tour();
        do_reset();

        // Reset state.
        chk("reset mv_addr", 32'(mv_addr), 32'd0);
        chk("reset cmd", 32'(cmd), 32'h0000);
        chk("reset cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);

        // Single-move decode vectors, applied as the first move of a tour.
        for (int i = 0; i < 11; i++) begin
            mem[0] = vecs[i].mv;
            do_reset();
            pulse_start();
            chk($sformatf("vec%0d busy in FETCH", i), 32'(busy), 32'd1);
            if (vecs[i].legal) begin
                leg($sformatf("vec%0d vert", i), vecs[i].v, 2);
                leg($sformatf("vec%0d horz", i), vecs[i].h, 0);
                chk($sformatf("vec%0d next addr", i), 32'(mv_addr), 32'd1);
                chk($sformatf("vec%0d busy after move", i), 32'(busy), 32'd1);
            end else begin
                tick();
                tick();
                chk($sformatf("vec%0d err", i), 32'(err), 32'd1);
                chk($sformatf("vec%0d busy at err", i), 32'(busy), 32'd0);
                chk($sformatf("vec%0d cmd_rdy at err", i), 32'(cmd_rdy), 32'd0);
                tick();
                chk($sformatf("vec%0d err one cycle", i), 32'(err), 32'd0);
            end
            $display("[TB] vector %0d mv=0x%02h legal=%0d", i, vecs[i].mv, vecs[i].legal);
        end

        // Full tour with protocol abuse on the first move.
        load_tour();
        do_reset();
        r0 = rdy_rises; d0 = done_cnt; e0 = err_cnt; s0 = addr_steps; b0 = addr_bad;
        pulse_start();
        begin
            int w;
            wait_rdy(10, w);
            chk("m0 vert latency", w, 2);
            chk("m0 vert cmd", 32'(cmd), 32'(vecs[0].v));
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start while busy cmd_rdy", 32'(cmd_rdy), 32'd1);
            chk("start while busy cmd", 32'(cmd), 32'(vecs[0].v));
            chk("start while busy addr", 32'(mv_addr), 32'd0);
            clr_cmd_rdy = 1'b1;
            send_resp   = 1'b1;
            tick();
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            chk("clr+resp in VERT cmd_rdy", 32'(cmd_rdy), 32'd0);
            tick();
            chk("resp in VERT ignored", 32'(cmd_rdy), 32'd0);
            chk("resp in VERT cmd held", 32'(cmd), 32'(vecs[0].v));
            clr_cmd_rdy = 1'b1;
            tick();
            clr_cmd_rdy = 1'b0;
            tick();
            chk("clr in WAIT_V cmd_rdy", 32'(cmd_rdy), 32'd0);
            chk("clr in WAIT_V busy", 32'(busy), 32'd1);
            chk("clr in WAIT_V cmd", 32'(cmd), 32'(vecs[0].v));
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            chk("WAIT_V resp horz cmd_rdy", 32'(cmd_rdy), 32'd1);
            leg("m0 horz", vecs[0].h, 0);
            $display("[TB] move 0 mv=0x%02h with protocol abuse", mem[0]);
        end
        for (int i = 1; i < NUM_MOVES; i++) run_move(i);
        chk("tour done pulse", 32'(done), 32'd1);
        chk("tour busy at done", 32'(busy), 32'd0);
        chk("tour cmd_rdy at done", 32'(cmd_rdy), 32'd0);
        tick();
        chk("tour done one cycle", 32'(done), 32'd0);
        chk("tour busy after", 32'(busy), 32'd0);
        tick();
        tick();
        chk("tour cmd_rdy assertions", rdy_rises - r0, 48);
        chk("tour done count", done_cnt - d0, 1);
        chk("tour err count", err_cnt - e0, 0);
        chk("tour addr steps", addr_steps - s0, 23);
        chk("tour addr order", addr_bad - b0, 0);
        chk("tour final addr", 32'(mv_addr), 32'd23);
        $display("[TB] full tour of %0d moves", NUM_MOVES);

        // Illegal move at index 3.
        load_tour();
        mem[3] = 8'h03;
        do_reset();
        r0 = rdy_rises; d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) run_move(i);
        tick();
        tick();
        chk("bad move err", 32'(err), 32'd1);
        chk("bad move busy", 32'(busy), 32'd0);
        chk("bad move cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("bad move addr", 32'(mv_addr), 32'd3);
        tick();
        tick();
        tick();
        chk("bad move rdy count", rdy_rises - r0, 6);
        chk("bad move done count", done_cnt - d0, 0);
        chk("bad move err count", err_cnt - e0, 1);
        $display("[TB] illegal move at index 3");

        // Reset during WAIT_H of move 10, then replay.
        load_tour();
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) run_move(i);
        leg("m10 vert", vecs[2].v, 2);
        begin
            int w;
            wait_rdy(10, w);
            chk("m10 horz cmd", 32'(cmd), 32'(vecs[2].h));
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset mv_addr", 32'(mv_addr), 32'd0);
        chk("midreset cmd", 32'(cmd), 32'h0000);
        chk("midreset cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset err", 32'(err), 32'd0);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("resp in IDLE ignored", 32'(busy), 32'd0);
        pulse_start();
        chk("replay mv_addr", 32'(mv_addr), 32'd0);
        run_move(0);
        chk("replay next addr", 32'(mv_addr), 32'd1);
        $display("[TB] reset during WAIT_H of move 10 and replay");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
